// File: rtl/bullet2_sprite_render.sv
// Bullet sprite pixel stage: box test and ROM address, sprite-index ROM read,
// then palette lookup into a registered RGB + opaque output. Three-cycle latency.
module bullet2_sprite_render #(
  parameter int COORD_W    = 10,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  localparam int ADDR_W    = $clog2(SPR_W*SPR_H*NUM_FRAMES)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_frame_start,
  input  logic               i_bullet_en,
  input  logic [COORD_W-1:0] i_bullet_x,
  input  logic [COORD_W-1:0] i_bullet_y,
  input  logic               i_pix_valid,
  input  logic [COORD_W-1:0] i_pix_x,
  input  logic [COORD_W-1:0] i_pix_y,
  output logic [ADDR_W-1:0]  o_rom_addr,
  input  logic [3:0]         i_rom_idx,
  input  logic [16*24-1:0]   i_palette,
  output logic               o_pix_valid,
  output logic               o_pix_opaque,
  output logic [23:0]        o_pix_rgb
);

  localparam int ANIM_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  logic               en_r;
  logic [COORD_W-1:0] bx_r;
  logic [COORD_W-1:0] by_r;
  logic [DIV_W-1:0]   div_r;
  logic [ANIM_W-1:0]  anim_r;

  logic               v1_r, h1_r, v2_r, h2_r;
  logic [ADDR_W-1:0]  rom_addr_r;
  logic               pix_valid_r, pix_opaque_r;
  logic [23:0]        pix_rgb_r;

  logic [COORD_W:0]   px_s, py_s, bx_s, by_s, dx_s, dy_s;
  logic               in_box_s;
  logic [ADDR_W-1:0]  addr_s;
  logic               opaque_s;
  logic [23:0]        rgb_s;

  // Position latch and animation divider, both advanced by the frame pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_r   <= 1'b0;
      bx_r   <= '0;
      by_r   <= '0;
      div_r  <= '0;
      anim_r <= '0;
    end else if (i_frame_start) begin
      en_r <= i_bullet_en;
      bx_r <= i_bullet_x;
      by_r <= i_bullet_y;
      if (div_r == DIV_W'(FRAME_DIV-1)) begin
        div_r  <= '0;
        anim_r <= (anim_r == ANIM_W'(NUM_FRAMES-1)) ? '0 : anim_r + ANIM_W'(1);
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
    end else begin
      en_r   <= en_r;
      bx_r   <= bx_r;
      by_r   <= by_r;
      div_r  <= div_r;
      anim_r <= anim_r;
    end
  end

  // Stage 0: box test in COORD_W+1 bits so a sprite hanging off the right edge does not wrap
  always_comb begin
    px_s     = {1'b0, i_pix_x};
    py_s     = {1'b0, i_pix_y};
    bx_s     = {1'b0, bx_r};
    by_s     = {1'b0, by_r};
    dx_s     = px_s - bx_s;
    dy_s     = py_s - by_s;
    in_box_s = en_r
             & (px_s >= bx_s) & (px_s < bx_s + (COORD_W+1)'(SPR_W))
             & (py_s >= by_s) & (py_s < by_s + (COORD_W+1)'(SPR_H));
    addr_s   = '0;
    if (in_box_s) begin
      addr_s = ADDR_W'(anim_r) * ADDR_W'(SPR_W*SPR_H)
             + ADDR_W'(dy_s) * ADDR_W'(SPR_W)
             + ADDR_W'(dx_s);
    end else begin
      addr_s = '0;
    end
  end

  // Stage 0/1 registers: ROM address plus valid/hit travelling alongside the ROM read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rom_addr_r <= '0;
      v1_r       <= 1'b0;
      h1_r       <= 1'b0;
      v2_r       <= 1'b0;
      h2_r       <= 1'b0;
    end else begin
      rom_addr_r <= addr_s;
      v1_r       <= i_pix_valid;
      h1_r       <= i_pix_valid & in_box_s;
      v2_r       <= v1_r;
      h2_r       <= h1_r;
    end
  end

  // Stage 2 combinational: index 0 is the transparent colour
  always_comb begin
    opaque_s = h2_r & (i_rom_idx != 4'd0);
    rgb_s    = 24'h000000;
    if (opaque_s) begin
      rgb_s = i_palette[24*i_rom_idx +: 24];
    end else begin
      rgb_s = 24'h000000;
    end
  end

  // Stage 2 output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_valid_r  <= 1'b0;
      pix_opaque_r <= 1'b0;
      pix_rgb_r    <= 24'h000000;
    end else begin
      pix_valid_r  <= v2_r;
      pix_opaque_r <= opaque_s;
      pix_rgb_r    <= rgb_s;
    end
  end

  assign o_rom_addr   = rom_addr_r;
  assign o_pix_valid  = pix_valid_r;
  assign o_pix_opaque = pix_opaque_r;
  assign o_pix_rgb    = pix_rgb_r;

endmodule

// File: tb/tb_bullet2_sprite_render.sv
// Scoreboard bench for bullet2_sprite_render: driver pushes expected results from
// a coordinate-level model, a negedge monitor pops and compares.
module tb_bullet2_sprite_render;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic         i_frame_start;
  logic         i_bullet_en;
  logic [9:0]   i_bullet_x, i_bullet_y;
  logic         i_pix_valid;
  logic [9:0]   i_pix_x, i_pix_y;
  logic [9:0]   o_rom_addr;
  logic [3:0]   i_rom_idx;
  logic [383:0] i_palette;
  logic         o_pix_valid, o_pix_opaque;
  logic [23:0]  o_pix_rgb;

  bullet2_sprite_render dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame_start(i_frame_start),
    .i_bullet_en(i_bullet_en), .i_bullet_x(i_bullet_x), .i_bullet_y(i_bullet_y),
    .i_pix_valid(i_pix_valid), .i_pix_x(i_pix_x), .i_pix_y(i_pix_y),
    .o_rom_addr(o_rom_addr), .i_rom_idx(i_rom_idx), .i_palette(i_palette),
    .o_pix_valid(o_pix_valid), .o_pix_opaque(o_pix_opaque), .o_pix_rgb(o_pix_rgb)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic opaque; logic [23:0] rgb; } pix_t;

  logic [3:0]  rom [0:1023];
  logic [23:0] pal [16];
  int          aq[$];
  pix_t        pq[$];
  logic [2:0]  vpipe;
  int          checks = 0;
  int          failures = 0;

  // model state: latched bullet and total frame pulses since reset
  int m_en, m_bx, m_by, m_pulses;

  // synchronous sprite ROM
  always @(posedge i_clk) i_rom_idx <= rom[o_rom_addr];

  // which cycles carried an accepted pixel
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) vpipe <= 3'b000;
    else          vpipe <= {vpipe[1:0], i_pix_valid};
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_bx = 0; m_by = 0; m_pulses = 0;
  endtask

  task automatic drive(input bit fs, input bit en, input int bx, input int by,
                       input bit v, input int px, input int py);
    int   inbox, addr, idx;
    pix_t e;
    @(posedge i_clk); #1;
    i_frame_start = fs; i_bullet_en = en;
    i_bullet_x = 10'(bx); i_bullet_y = 10'(by);
    i_pix_valid = v; i_pix_x = 10'(px); i_pix_y = 10'(py);
    if (v) begin
      inbox = (m_en != 0) && px >= m_bx && px < m_bx + 16 && py >= m_by && py < m_by + 16;
      addr  = inbox ? ((m_pulses / 8) % 4) * 256 + (py - m_by) * 16 + (px - m_bx) : 0;
      idx   = int'(rom[addr]);
      e.opaque = (inbox != 0) && (idx != 0);
      e.rgb    = e.opaque ? pal[idx] : 24'h000000;
      aq.push_back(addr);
      pq.push_back(e);
    end
    if (fs) begin
      m_pulses++; m_en = en; m_bx = bx; m_by = by;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  task automatic mid_reset();
    @(posedge i_clk); #1;
    i_rst_n = 1'b0; i_pix_valid = 1'b0; i_frame_start = 1'b0;
    #1;
    chk("rst_valid", int'(o_pix_valid), 0);
    chk("rst_opaque", int'(o_pix_opaque), 0);
    chk("rst_rgb", int'(o_pix_rgb), 0);
    chk("rst_addr", int'(o_rom_addr), 0);
    aq.delete(); pq.delete();
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  // monitor: compare DUT outputs against the scoreboard
  initial begin
    int   a;
    pix_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst_n) begin
        chk("valid_timing", int'(o_pix_valid), int'(vpipe[2]));
        if (vpipe[0]) begin
          if (aq.size() == 0) chk("addr_underflow", 1, 0);
          else begin a = aq.pop_front(); chk("rom_addr", int'(o_rom_addr), a); end
        end
        if (o_pix_valid) begin
          if (pq.size() == 0) chk("pix_underflow", 1, 0);
          else begin
            e = pq.pop_front();
            chk("opaque", int'(o_pix_opaque), int'(e.opaque));
            chk("rgb", int'(o_pix_rgb), int'(e.rgb));
          end
        end else begin
          chk("idle_rgb", int'(o_pix_rgb), 0);
          chk("idle_opaque", int'(o_pix_opaque), 0);
        end
      end
    end
  end

  initial begin
    int bx, by, en;
    for (int i = 0; i < 1024; i++) rom[i] = 4'($urandom_range(0, 15));
    rom[0] = 4'd1; rom[255] = 4'd0; rom[256] = 4'd5;
    pal[0] = 24'h000000;
    pal[1] = 24'hfefe00;
    for (int k = 2; k < 16; k++) pal[k] = 24'($urandom);
    for (int k = 0; k < 16; k++) i_palette[24*k +: 24] = pal[k];
    i_rst_n = 1'b0; i_frame_start = 1'b0; i_bullet_en = 1'b0;
    i_bullet_x = 10'd0; i_bullet_y = 10'd0; i_pix_valid = 1'b0;
    i_pix_x = 10'd0; i_pix_y = 10'd0;
    model_reset();
    #1;
    chk("por_valid", int'(o_pix_valid), 0);
    chk("por_rgb", int'(o_pix_rgb), 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    // latency/hit, transparency, box edge
    drive(1'b1, 1'b1, 100, 50, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 100, 50);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 115, 65);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 116, 50);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 99, 50);
    idle(2);
    // screen edge
    drive(1'b1, 1'b1, 1020, 0, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1023, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1021, 15);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1022, 16);
    // mid-stream reset
    drive(1'b0, 1'b0, 0, 0, 1'b1, 1020, 1);
    mid_reset();
    // animation: 8 pulses -> frame 1, 32 pulses -> frame 0
    drive(1'b1, 1'b1, 300, 200, 1'b0, 0, 0);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b1, 300, 200, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 300, 200);
    for (int i = 0; i < 24; i++) drive(1'b1, 1'b1, 300, 200, 1'b0, 0, 0);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 300, 200);
    // same-cycle frame start uses old position
    drive(1'b1, 1'b1, 500, 400, 1'b1, 305, 210);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 505, 410);
    drive(1'b1, 1'b0, 500, 400, 1'b1, 501, 401);
    drive(1'b0, 1'b0, 0, 0, 1'b1, 501, 401);
    idle(3);

    // randomized stream clustered around the bullet
    bx = 0; by = 0; en = 1;
    for (int n = 0; n < 2000; n++) begin
      bit fs;
      int px, py;
      fs = ($urandom_range(0, 19) == 0);
      if (fs) begin
        bx = (n % 7 == 0) ? 1010 + $urandom_range(0, 13) : $urandom_range(0, 1023);
        by = $urandom_range(0, 1023);
        en = ($urandom_range(0, 3) != 0);
      end
      px = (m_bx + $urandom_range(0, 19) - 2) & 1023;
      py = (m_by + $urandom_range(0, 19) - 2) & 1023;
      drive(fs, en[0], bx, by, ($urandom_range(0, 4) != 0), px, py);
    end
    idle(6);
    chk("addr_q_drained", aq.size(), 0);
    chk("pix_q_drained", pq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
